// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: decoded instruction
// vector, FSM state encoding and classification functions.
package lsu_pkg;

    localparam int STRB_W = 4;
    localparam int OFF_W  = 2;

    typedef struct packed {
        logic lb;
        logic lh;
        logic lw;
        logic lbu;
        logic lhu;
        logic sb;
        logic sh;
        logic sw;
        logic addi;
        logic add;
    } instructions;

    localparam logic [9:0] LOAD_MASK  = 10'b11111_000_00;
    localparam logic [9:0] STORE_MASK = 10'b00000_111_00;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

    function automatic logic is_load(input instructions i);
        return |(i & LOAD_MASK);
    endfunction

    function automatic logic is_store(input instructions i);
        return |(i & STORE_MASK);
    endfunction

    function automatic logic is_mem(input instructions i);
        return is_load(i) | is_store(i);
    endfunction

    // Halfwords need an even address, words need a multiple of four.
    function automatic logic is_misaligned(input instructions i, input logic [OFF_W-1:0] off);
        return ((i.lh | i.lhu | i.sh) & off[0]) | ((i.lw | i.sw) & (off != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobes/replicated store data and load
// lane extraction with sign or zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  instructions        instr,
    input  logic [OFF_W-1:0]   off,
    input  logic [31:0]        rs2_v,
    input  logic [31:0]        rdata,
    output logic [STRB_W-1:0]  wstrb,
    output logic [31:0]        wdata,
    output logic [31:0]        load_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    genvar gi;
    generate
        for (gi = 0; gi < STRB_W; gi++) begin : g_lane
            assign wstrb[gi] = is_store(instr) &
                               (instr.sw |
                                (instr.sh & (off[1] == 1'(gi / 2))) |
                                (instr.sb & (off == 2'(gi))));
            assign wdata[8*gi +: 8] = instr.sw ? rs2_v[8*gi +: 8] :
                                      instr.sh ? rs2_v[8*(gi % 2) +: 8] :
                                                 rs2_v[7:0];
        end
    endgenerate

    assign byte_lane = rdata[{off, 3'b000} +: 8];
    assign half_lane = rdata[{off[1], 4'b0000} +: 16];

    always_comb begin
        load_data = '0;
        if (is_load(instr)) begin
            if (instr.lb)       load_data = {{24{byte_lane[7]}}, byte_lane};
            else if (instr.lbu) load_data = {24'd0, byte_lane};
            else if (instr.lh)  load_data = {{16{half_lane[15]}}, half_lane};
            else if (instr.lhu) load_data = {16'd0, half_lane};
            else                load_data = rdata;
        end
    end

endmodule

// File: rtl/lsu.sv
// Memory-access stage: single-outstanding request FSM with capture
// registers, optional response timeout and result/flag reporting.
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               enable,
    input  instructions        instr,
    input  logic [31:0]        alu_result,
    input  logic [31:0]        rs2_v,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [31:0]        mem_addr,
    output logic               mem_we,
    output logic [STRB_W-1:0]  mem_wstrb,
    output logic [31:0]        mem_wdata,
    input  logic               mem_resp_valid,
    input  logic [31:0]        mem_rdata,
    output logic [31:0]        result,
    output logic               completed,
    output logic               misaligned,
    output logic               bus_err
);

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    lsu_state_t  state_reg,  state_next;
    instructions instr_reg,  instr_next;
    logic [31:0] addr_reg,   addr_next;
    logic [31:0] rs2_reg,    rs2_next;
    logic [31:0] cnt_reg,    cnt_next;
    logic [31:0] result_reg, result_next;
    logic        mis_reg,    mis_next;
    logic        err_reg,    err_next;
    logic [31:0] load_data;

    lsu_align u_align (
        .instr     (instr_reg),
        .off       (addr_reg[OFF_W-1:0]),
        .rs2_v     (rs2_reg),
        .rdata     (mem_rdata),
        .wstrb     (mem_wstrb),
        .wdata     (mem_wdata),
        .load_data (load_data)
    );

    always_comb begin
        state_next  = state_reg;
        instr_next  = instr_reg;
        addr_next   = addr_reg;
        rs2_next    = rs2_reg;
        cnt_next    = cnt_reg;
        result_next = result_reg;
        mis_next    = mis_reg;
        err_next    = err_reg;
        case (state_reg)
            IDLE: begin
                if (enable) begin
                    mis_next = 1'b0;
                    err_next = 1'b0;
                    if (!is_mem(instr)) begin
                        result_next = alu_result;
                        state_next  = DONE;
                    end else if (is_misaligned(instr, alu_result[OFF_W-1:0])) begin
                        result_next = '0;
                        mis_next    = 1'b1;
                        state_next  = DONE;
                    end else begin
                        instr_next  = instr;
                        addr_next   = alu_result;
                        rs2_next    = rs2_v;
                        state_next  = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    cnt_next   = '0;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // A response arriving on the expiry cycle takes priority over the timeout.
                if (mem_resp_valid) begin
                    result_next = is_load(instr_reg) ? load_data : 32'd0;
                    state_next  = DONE;
                end else if (TIMEOUT_CYCLES != 0 && cnt_reg == TO_LAST) begin
                    result_next = '0;
                    err_next    = 1'b1;
                    state_next  = DONE;
                end else begin
                    cnt_next = cnt_reg + 32'd1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg  <= IDLE;
            instr_reg  <= '0;
            addr_reg   <= '0;
            rs2_reg    <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
            mis_reg    <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            instr_reg  <= instr_next;
            addr_reg   <= addr_next;
            rs2_reg    <= rs2_next;
            cnt_reg    <= cnt_next;
            result_reg <= result_next;
            mis_reg    <= mis_next;
            err_reg    <= err_next;
        end
    end

    assign mem_req_valid = (state_reg == REQ);
    assign mem_addr      = {addr_reg[31:2], 2'b00};
    assign mem_we        = is_store(instr_reg);
    assign completed     = (state_reg == DONE);
    assign misaligned    = completed & mis_reg;
    assign bus_err       = completed & err_reg;
    assign result        = result_reg;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: one task per scenario with inline expected-value checks.
module tb_lsu;
    import lsu_pkg::*;

    localparam int TO = 4;
    localparam int K_LB = 0, K_LH = 1, K_LW = 2, K_LBU = 3, K_LHU = 4;
    localparam int K_SB = 5, K_SH = 6, K_SW = 7, K_ADDI = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enable = 1'b0;
    instructions instr = '0;
    logic [31:0] alu_result = '0;
    logic [31:0] rs2_v = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] result;
    logic        completed;
    logic        misaligned;
    logic        bus_err;

    int errors = 0;
    int checks = 0;

    lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .instr(instr),
        .alu_result(alu_result), .rs2_v(rs2_v),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_resp_valid(mem_resp_valid),
        .mem_rdata(mem_rdata), .result(result), .completed(completed),
        .misaligned(misaligned), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    function automatic instructions op(input int k);
        instructions i;
        i = '0;
        case (k)
            K_LB:    i.lb = 1'b1;
            K_LH:    i.lh = 1'b1;
            K_LW:    i.lw = 1'b1;
            K_LBU:   i.lbu = 1'b1;
            K_LHU:   i.lhu = 1'b1;
            K_SB:    i.sb = 1'b1;
            K_SH:    i.sh = 1'b1;
            K_SW:    i.sw = 1'b1;
            default: i.addi = 1'b1;
        endcase
        return i;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int k, input logic [31:0] a, input logic [31:0] d);
        instr = op(k);
        alu_result = a;
        rs2_v = d;
        enable = 1'b1;
        tick();
        enable = 1'b0;
    endtask

    // Accept immediately, respond on the following cycle.
    task automatic handshake(input logic [31:0] rd);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata = rd;
        tick();
        mem_resp_valid = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick();
        tick();
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", mem_req_valid); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", mem_we); end
        checks++; if (completed !== 1'b0) begin errors++; $display("FAIL reset_completed: got %b want 0", completed); end
        checks++; if ({misaligned, bus_err} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {misaligned, bus_err}); end
        checks++; if (mem_wstrb !== 4'b0000) begin errors++; $display("FAIL reset_wstrb: got %b want 0000", mem_wstrb); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
        checks++; if ({mem_addr, mem_wdata} !== 64'h0) begin errors++; $display("FAIL reset_addr_wdata: got %h %h want 0 0", mem_addr, mem_wdata); end
        rstn = 1'b1;
        tick();
        $display("txn reset done");
    endtask

    task automatic test_passthrough();
        launch(K_ADDI, 32'h1234, 32'h0);
        checks++; if (completed !== 1'b1) begin errors++; $display("FAIL pass_completed: got %b want 1", completed); end
        checks++; if (result !== 32'h1234) begin errors++; $display("FAIL pass_result: got %h want 00001234", result); end
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL pass_no_req: got %b want 0", mem_req_valid); end
        checks++; if ({misaligned, bus_err} !== 2'b00) begin errors++; $display("FAIL pass_flags: got %b want 00", {misaligned, bus_err}); end
        tick();
        checks++; if (completed !== 1'b0) begin errors++; $display("FAIL pass_pulse: got %b want 0", completed); end
        checks++; if (result !== 32'h1234) begin errors++; $display("FAIL pass_hold: got %h want 00001234", result); end
        $display("txn addi alu=00001234 result=%h", result);
    endtask

    task automatic test_store_sb();
        launch(K_SB, 32'h103, 32'hAB);
        checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL sb_valid: got %b want 1", mem_req_valid); end
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL sb_addr: got %h want 00000100", mem_addr); end
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL sb_we: got %b want 1", mem_we); end
        checks++; if (mem_wstrb !== 4'b1000) begin errors++; $display("FAIL sb_wstrb: got %b want 1000", mem_wstrb); end
        checks++; if (mem_wdata !== 32'hABABABAB) begin errors++; $display("FAIL sb_wdata: got %h want abababab", mem_wdata); end
        handshake(32'hFFFF_FFFF);
        checks++; if (completed !== 1'b1) begin errors++; $display("FAIL sb_completed: got %b want 1", completed); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL sb_result: got %h want 0", result); end
        $display("txn sb addr=00000103 wstrb=%b wdata=%h", mem_wstrb, mem_wdata);
        tick();
    endtask

    task automatic test_store_sw();
        launch(K_SW, 32'h108, 32'hCAFE_F00D);
        checks++; if (mem_wstrb !== 4'b1111) begin errors++; $display("FAIL sw_wstrb: got %b want 1111", mem_wstrb); end
        checks++; if (mem_wdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL sw_wdata: got %h want cafef00d", mem_wdata); end
        checks++; if (mem_addr !== 32'h108) begin errors++; $display("FAIL sw_addr: got %h want 00000108", mem_addr); end
        handshake(32'h0);
        checks++; if (completed !== 1'b1) begin errors++; $display("FAIL sw_completed: got %b want 1", completed); end
        $display("txn sw addr=00000108 wstrb=1111");
        tick();
    endtask

    task automatic test_loads();
        int          k[7]  = '{K_LB, K_LBU, K_LHU, K_LH, K_LB, K_LW, K_LH};
        logic [31:0] a[7]  = '{32'h102, 32'h102, 32'h002, 32'h002, 32'h101, 32'h104, 32'h000};
        logic [31:0] rd[7] = '{32'h0080_0000, 32'h0080_0000, 32'h0080_0000, 32'h8000_0000,
                               32'h0000_7F00, 32'hDEAD_BEEF, 32'h0000_FFFE};
        logic [31:0] ex[7] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_0080, 32'hFFFF_8000,
                               32'h0000_007F, 32'hDEAD_BEEF, 32'hFFFF_FFFE};
        logic [31:0] wa;
        for (int i = 0; i < 7; i++) begin
            launch(k[i], a[i], 32'h5A5A_5A5A);
            wa = a[i] & 32'hFFFF_FFFC;
            checks++; if (mem_addr !== wa) begin errors++; $display("FAIL load%0d_addr: got %h want %h", i, mem_addr, wa); end
            checks++; if ({mem_we, mem_wstrb} !== 5'b0) begin errors++; $display("FAIL load%0d_we_wstrb: got %b want 00000", i, {mem_we, mem_wstrb}); end
            handshake(rd[i]);
            checks++; if (completed !== 1'b1) begin errors++; $display("FAIL load%0d_completed: got %b want 1", i, completed); end
            checks++; if (result !== ex[i]) begin errors++; $display("FAIL load%0d_result: got %h want %h", i, result, ex[i]); end
            $display("txn load%0d addr=%h rdata=%h result=%h", i, a[i], rd[i], result);
            tick();
        end
    endtask

    task automatic test_misaligned();
        int          k[5] = '{K_LW, K_SW, K_LH, K_LHU, K_SH};
        logic [31:0] a[5] = '{32'h101, 32'h102, 32'h103, 32'h001, 32'h003};
        for (int i = 0; i < 5; i++) begin
            launch(k[i], a[i], 32'h1111_2222);
            checks++; if ({completed, misaligned, bus_err} !== 3'b110) begin errors++; $display("FAIL mis%0d_flags: got %b want 110", i, {completed, misaligned, bus_err}); end
            checks++; if (result !== 32'h0) begin errors++; $display("FAIL mis%0d_result: got %h want 0", i, result); end
            checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL mis%0d_no_req: got %b want 0", i, mem_req_valid); end
            tick();
            checks++; if ({completed, misaligned} !== 2'b00) begin errors++; $display("FAIL mis%0d_clear: got %b want 00", i, {completed, misaligned}); end
            $display("txn misaligned%0d addr=%h", i, a[i]);
        end
    endtask

    task automatic test_ready_stall();
        launch(K_SH, 32'h102, 32'h1234_BEEF);
        for (int i = 0; i < 5; i++) begin
            checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL stall%0d_valid: got %b want 1", i, mem_req_valid); end
            checks++; if ({mem_addr, mem_we, mem_wstrb, mem_wdata} !== {32'h100, 1'b1, 4'b1100, 32'hBEEF_BEEF})
                begin errors++; $display("FAIL stall%0d_fields: got %h %b %b %h want 00000100 1 1100 beefbeef", i, mem_addr, mem_we, mem_wstrb, mem_wdata); end
            tick();
        end
        handshake(32'h0);
        checks++; if (completed !== 1'b1) begin errors++; $display("FAIL stall_completed: got %b want 1", completed); end
        $display("txn sh stalled 5 cycles wstrb=1100");
        tick();
    endtask

    task automatic test_resp_at_expiry();
        launch(K_LW, 32'h200, 32'h0);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int i = 0; i < TO - 1; i++) tick();
        checks++; if (completed !== 1'b0) begin errors++; $display("FAIL expiry_early: got %b want 0", completed); end
        mem_resp_valid = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        tick();
        mem_resp_valid = 1'b0;
        checks++; if ({completed, bus_err} !== 2'b10) begin errors++; $display("FAIL expiry_resp_wins: got %b want 10", {completed, bus_err}); end
        checks++; if (result !== 32'h5555_AAAA) begin errors++; $display("FAIL expiry_result: got %h want 5555aaaa", result); end
        $display("txn lw response on expiry cycle result=%h", result);
        tick();
    endtask

    task automatic test_timeout();
        launch(K_LW, 32'h200, 32'h0);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL to_accepted: got %b want 0", mem_req_valid); end
        for (int i = 1; i < TO; i++) begin
            tick();
            checks++; if (completed !== 1'b0) begin errors++; $display("FAIL to_wait%0d: got %b want 0", i, completed); end
        end
        tick();
        checks++; if ({completed, bus_err, misaligned} !== 3'b110) begin errors++; $display("FAIL to_flags: got %b want 110", {completed, bus_err, misaligned}); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL to_result: got %h want 0", result); end
        tick();
        checks++; if ({completed, bus_err} !== 2'b00) begin errors++; $display("FAIL to_clear: got %b want 00", {completed, bus_err}); end
        $display("txn lw timeout after %0d cycles", TO);
    endtask

    task automatic test_enable_ignored();
        launch(K_LW, 32'h304, 32'h0);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        launch(K_ADDI, 32'h777, 32'h0);
        checks++; if (completed !== 1'b0) begin errors++; $display("FAIL ign_no_complete: got %b want 0", completed); end
        mem_resp_valid = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        tick();
        mem_resp_valid = 1'b0;
        checks++; if (result !== 32'h0BAD_F00D) begin errors++; $display("FAIL ign_result: got %h want 0badf00d", result); end
        tick();
        tick();
        checks++; if ({completed, result} !== {1'b0, 32'h0BAD_F00D}) begin errors++; $display("FAIL ign_no_queue: got %b %h want 0 0badf00d", completed, result); end
        $display("txn lw with stray enable result=0badf00d");
    endtask

    task automatic test_reset_mid();
        launch(K_LW, 32'h300, 32'h0);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        mem_resp_valid = 1'b1;
        mem_rdata = 32'h1111_1111;
        tick();
        mem_resp_valid = 1'b0;
        checks++; if ({completed, mem_req_valid} !== 2'b00) begin errors++; $display("FAIL rstmid_idle: got %b want 00", {completed, mem_req_valid}); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL rstmid_result: got %h want 0", result); end
        tick();
        checks++; if (completed !== 1'b0) begin errors++; $display("FAIL rstmid_late: got %b want 0", completed); end
        $display("txn reset during WAIT, late response dropped");
    endtask

    task automatic test_back_to_back();
        instr = op(K_ADDI);
        alu_result = 32'h1;
        enable = 1'b1;
        tick();
        checks++; if ({completed, result} !== {1'b1, 32'h1}) begin errors++; $display("FAIL b2b_first: got %b %h want 1 00000001", completed, result); end
        alu_result = 32'h2;
        tick();
        checks++; if ({completed, result} !== {1'b0, 32'h1}) begin errors++; $display("FAIL b2b_done_ignore: got %b %h want 0 00000001", completed, result); end
        tick();
        enable = 1'b0;
        checks++; if ({completed, result} !== {1'b1, 32'h2}) begin errors++; $display("FAIL b2b_second: got %b %h want 1 00000002", completed, result); end
        tick();
        $display("txn back-to-back addi results 1,2");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_passthrough();
        test_store_sb();
        test_store_sw();
        test_loads();
        test_misaligned();
        test_ready_stall();
        test_resp_at_expiry();
        test_timeout();
        test_enable_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
